// File: rtl/idct_pad_bridge.sv
// rtl/idct_pad_bridge.sv - pad-side bridge: beat-to-word assembler and show-ahead output FIFO for the IDCT core
module idct_pad_bridge #(
  parameter int PIN_W        = 8,
  parameter int WORD_W       = 16,
  parameter int OUT_W        = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rstn,
  // pad input beats
  input  logic [PIN_W-1:0]  din,
  input  logic              din_valid,
  input  logic              din_sof,
  input  logic              mode,
  // assembled words towards the core
  output logic [WORD_W-1:0] core_din,
  output logic              core_din_valid,
  output logic              core_mode,
  // core output samples
  input  logic [OUT_W-1:0]  core_dout,
  input  logic              core_dout_valid,
  input  logic              core_dout_mode,
  input  logic              core_dout_start,
  output logic              core_stall,
  // buffered samples towards the pads
  output logic [OUT_W-1:0]  dout,
  output logic              dout_mode,
  output logic              dout_start,
  output logic              dout_valid,
  input  logic              dout_ready,
  // sticky error flags
  input  logic              clr_err,
  output logic              err_resync,
  output logic              err_overflow
);

  localparam int RATIO  = WORD_W / PIN_W;
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int ENT_W  = OUT_W + 2;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     STALL_CNT = CW'(FIFO_DEPTH - AFULL_MARGIN);

  // ---------------------------------------------------------------
  // Input assembler
  // ---------------------------------------------------------------
  logic [BEAT_W-1:0] r_beat;
  logic [WORD_W-1:0] r_acc;
  logic              r_mode_lat;
  logic [WORD_W-1:0] r_core_din;
  logic              r_core_din_valid;
  logic              r_core_mode;
  logic              r_err_resync;

  logic [BEAT_W-1:0] w_beat_eff;
  logic [WORD_W-1:0] w_word;
  logic              w_word_mode;
  logic              w_last;
  logic              w_resync_evt;

  // A sof beat restarts the word; otherwise the running counter selects the slot
  always_comb begin
    w_beat_eff   = (din_valid && din_sof) ? '0 : r_beat;
    w_last       = din_valid && (w_beat_eff == LAST_BEAT);
    w_resync_evt = din_valid && din_sof && (r_beat != '0);
    w_word_mode  = (w_beat_eff == '0) ? mode : r_mode_lat;
    w_word       = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (w_beat_eff == BEAT_W'(k)) begin
        w_word[k*PIN_W +: PIN_W] = din;
      end
    end
  end

  // Beat counter, partial-word accumulator and word output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat           <= '0;
      r_acc            <= '0;
      r_mode_lat       <= 1'b0;
      r_core_din       <= '0;
      r_core_din_valid <= 1'b0;
      r_core_mode      <= 1'b0;
    end else begin
      r_core_din_valid <= 1'b0;
      if (din_valid) begin
        r_acc <= w_word;
        if (w_beat_eff == '0) begin
          r_mode_lat <= mode;
        end
        if (w_last) begin
          r_core_din       <= w_word;
          r_core_mode      <= w_word_mode;
          r_core_din_valid <= 1'b1;
          r_beat           <= '0;
        end else begin
          r_beat <= w_beat_eff + 1'b1;
        end
      end
    end
  end

  // Sticky resync flag; a new discard in the same cycle beats the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_resync <= 1'b0;
    end else if (w_resync_evt) begin
      r_err_resync <= 1'b1;
    end else if (clr_err) begin
      r_err_resync <= 1'b0;
    end
  end

  assign core_din       = r_core_din;
  assign core_din_valid = r_core_din_valid;
  assign core_mode      = r_core_mode;
  assign err_resync     = r_err_resync;

  // ---------------------------------------------------------------
  // Output FIFO (show-ahead)
  // ---------------------------------------------------------------
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_core_stall;
  logic             r_err_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_ovf_evt;
  logic [CW-1:0]    w_count_nxt;
  logic [ENT_W-1:0] w_head;

  // Accept/pop qualification and next occupancy; a write on full is dropped even if a pop happens
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == '0);
    w_wr        = core_dout_valid && !w_full;
    w_rd        = dout_ready && !w_empty;
    w_ovf_evt   = core_dout_valid && w_full;
    w_count_nxt = r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_rd};
    w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  // Entry storage; contents need no reset since the head is masked while empty
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {core_dout_start, core_dout_mode, core_dout};
    end
  end

  // Pointers, occupancy and the registered almost-full stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_core_stall <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count      <= w_count_nxt;
      r_core_stall <= (w_count_nxt >= STALL_CNT);
    end
  end

  // Sticky overflow flag; a dropped write in the same cycle beats the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_err_overflow <= 1'b1;
    end else if (clr_err) begin
      r_err_overflow <= 1'b0;
    end
  end

  assign dout         = w_head[OUT_W-1:0];
  assign dout_mode    = w_head[OUT_W];
  assign dout_start   = w_head[OUT_W+1];
  assign dout_valid   = !w_empty;
  assign core_stall   = r_core_stall;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_idct_pad_bridge.sv
// tb/tb_idct_pad_bridge.sv - directed self-checking bench for idct_pad_bridge
module tb_idct_pad_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_sof;
  logic        mode;
  logic [15:0] core_din;
  logic        core_din_valid;
  logic        core_mode;
  logic [7:0]  core_dout;
  logic        core_dout_valid;
  logic        core_dout_mode;
  logic        core_dout_start;
  logic        core_stall;
  logic [7:0]  dout;
  logic        dout_mode;
  logic        dout_start;
  logic        dout_valid;
  logic        dout_ready;
  logic        clr_err;
  logic        err_resync;
  logic        err_overflow;

  int n_checks = 0;
  int n_errors = 0;

  idct_pad_bridge #(
    .PIN_W(8), .WORD_W(16), .OUT_W(8), .FIFO_DEPTH(16), .AFULL_MARGIN(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .din(din), .din_valid(din_valid), .din_sof(din_sof), .mode(mode),
    .core_din(core_din), .core_din_valid(core_din_valid), .core_mode(core_mode),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .core_dout_mode(core_dout_mode), .core_dout_start(core_dout_start),
    .core_stall(core_stall),
    .dout(dout), .dout_mode(dout_mode), .dout_start(dout_start),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .clr_err(clr_err), .err_resync(err_resync), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic m, input logic sof);
    din = d; mode = m; din_sof = sof; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din_sof = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic m, input logic st);
    core_dout = d; core_dout_mode = m; core_dout_start = st; core_dout_valid = 1'b1;
    tick();
    core_dout_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; din = '0; din_valid = 1'b0; din_sof = 1'b0; mode = 1'b0;
    core_dout = '0; core_dout_valid = 1'b0; core_dout_mode = 1'b0; core_dout_start = 1'b0;
    dout_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    check("rst_core_din", core_din, 0);
    check("rst_core_din_valid", core_din_valid, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_stall", core_stall, 0);
    check("rst_errs", {err_resync, err_overflow}, 0);
    rstn = 1'b1;
    tick();

    // Assembly with idle gap
    beat(8'h34, 1'b1, 1'b0);
    check("asm_no_early_pulse", core_din_valid, 0);
    repeat (3) tick();
    beat(8'h12, 1'b0, 1'b0);
    check("asm_valid", core_din_valid, 1);
    check("asm_word", core_din, 16'h1234);
    check("asm_mode", core_mode, 1);
    tick();
    check("asm_pulse_one_cycle", core_din_valid, 0);
    check("asm_hold", core_din, 16'h1234);

    // Resync discards the partial word
    beat(8'hAA, 1'b1, 1'b0);
    beat(8'h55, 1'b0, 1'b1);
    check("resync_flag", err_resync, 1);
    check("resync_no_pulse", core_din_valid, 0);
    beat(8'h66, 1'b1, 1'b0);
    check("resync_word", core_din, 16'h6655);
    check("resync_valid", core_din_valid, 1);
    check("resync_mode", core_mode, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("resync_clr", err_resync, 0);

    // sof without valid is ignored
    beat(8'h11, 1'b0, 1'b0);
    din_sof = 1'b1; tick(); din_sof = 1'b0;
    beat(8'h22, 1'b0, 1'b0);
    check("sof_novalid_word", core_din, 16'h2211);
    check("sof_novalid_noerr", err_resync, 0);

    // FIFO flow
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), 1'b0, 1'b0);
      check("flow_head_kept", dout, 1);
      check("flow_valid", dout_valid, 1);
    end
    dout_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("flow_order", dout, 32'(i));
      tick();
    end
    check("flow_empty", dout_valid, 0);
    check("flow_empty_data", dout, 0);
    dout_ready = 1'b0;

    // Full, stall and overflow
    for (int i = 1; i <= 16; i++) begin
      push(8'(8'h10 + i - 1), 1'b0, 1'b0);
      check($sformatf("stall_after_%0d", i), core_stall, (i >= 12) ? 1 : 0);
    end
    check("full_no_ovf_yet", err_overflow, 0);
    push(8'hFF, 1'b0, 1'b0);
    check("ovf_set", err_overflow, 1);
    check("ovf_head", dout, 8'h10);
    // write on full with a pop and a clear in the same cycle
    core_dout = 8'hEE; core_dout_valid = 1'b1; dout_ready = 1'b1; clr_err = 1'b1;
    tick();
    core_dout_valid = 1'b0; clr_err = 1'b0;
    check("ovf_set_beats_clear", err_overflow, 1);
    for (int i = 1; i <= 15; i++) begin
      check("full_drain_order", dout, 32'(8'h10 + i));
      tick();
    end
    check("full_drained", dout_valid, 0);
    check("stall_drops", core_stall, 0);
    dout_ready = 1'b0;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clr", err_overflow, 0);

    // Simultaneous read and write at count 1
    push(8'h03, 1'b1, 1'b0);
    check("sim_head_pre", {dout_start, dout_mode, dout}, {2'b01, 8'h03});
    core_dout = 8'h07; core_dout_mode = 1'b0; core_dout_start = 1'b1;
    core_dout_valid = 1'b1; dout_ready = 1'b1;
    tick();
    core_dout_valid = 1'b0;
    check("sim_head_post", {dout_start, dout_mode, dout}, {2'b10, 8'h07});
    check("sim_valid", dout_valid, 1);
    tick();
    check("sim_count_was_1", dout_valid, 0);

    // Write into empty FIFO with ready high: stored, not popped
    push(8'h09, 1'b0, 1'b0);
    check("empty_wr_ready_valid", dout_valid, 1);
    check("empty_wr_ready_data", dout, 8'h09);
    tick();
    check("empty_wr_ready_pop", dout_valid, 0);
    dout_ready = 1'b0;

    // Asynchronous reset mid-operation
    push(8'hA1, 1'b0, 1'b1);
    push(8'hA2, 1'b0, 1'b0);
    push(8'hA3, 1'b0, 1'b0);
    beat(8'hAB, 1'b1, 1'b0);
    beat(8'hCC, 1'b0, 1'b1);
    check("pre_rst_err", err_resync, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_dout_valid", dout_valid, 0);
    check("arst_dout", {dout_start, dout_mode, dout}, 0);
    check("arst_core_din", core_din, 0);
    check("arst_errs", {err_resync, err_overflow, core_stall, core_mode}, 0);
    tick();
    rstn = 1'b1;
    tick();
    beat(8'hCD, 1'b1, 1'b0);
    check("post_rst_no_pulse", core_din_valid, 0);
    beat(8'hEF, 1'b0, 1'b0);
    check("post_rst_word", core_din, 16'hEFCD);
    check("post_rst_mode", core_mode, 1);
    check("post_rst_valid", core_din_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idct_pad_bridge.md
# idct_pad_bridge

Parametrised pad-side I/O bridge between chip pads and the IDCT core, with a narrow input pin bus and a buffered, flow-controlled output. Input beats of `PIN_W` bits are assembled into `WORD_W`-bit coefficients for the core. Core output samples are buffered in a show-ahead FIFO and drained under an external `dout_ready` handshake. The bridge sits between the pad ring and the IDCT top level, replacing direct pad-to-core wiring.

## Interface

Parameters:
- `PIN_W`, 8: input data pins per beat; `WORD_W % PIN_W == 0`.
- `WORD_W`, 16: core input word width; `RATIO = WORD_W/PIN_W` beats per word.
- `OUT_W`, 8: core/pad output data width, 1..16.
- `FIFO_DEPTH`, 16: output FIFO entries; power of 2, ≥2.
- `AFULL_MARGIN`, 4: `core_stall` asserts when count ≥ `FIFO_DEPTH-AFULL_MARGIN`; range 1..`FIFO_DEPTH-1`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock.
- `rstn` in 1: asynchronous active-low reset.
- `din` in `PIN_W`: input beat from pads.
- `din_valid` in 1: beat qualifier.
- `din_sof` in 1: with `din_valid`, marks the beat as beat 0 of a word (resync).
- `mode` in 1: mode flag, sampled on beat 0.
- `core_din` out `WORD_W`: assembled word.
- `core_din_valid` out 1: one-cycle pulse per word.
- `core_mode` out 1: mode captured with the word.
- `core_dout` in `OUT_W`: core output sample.
- `core_dout_valid` in 1: core sample qualifier (FIFO write).
- `core_dout_mode` in 1: mode tag for the sample.
- `core_dout_start` in 1: block-start tag for the sample.
- `core_stall` out 1: FIFO almost full; registered.
- `dout` out `OUT_W`: FIFO head data.
- `dout_mode` out 1: FIFO head mode tag.
- `dout_start` out 1: FIFO head start tag.
- `dout_valid` out 1: FIFO non-empty.
- `dout_ready` in 1: external consumer accepts the head.
- `clr_err` in 1: synchronous clear of sticky flags.
- `err_resync` out 1: sticky; a partial word was discarded.
- `err_overflow` out 1: sticky; a write was dropped on full.

## Operation

- **Reset values:** all outputs 0. Beat counter = 0, FIFO empty, sticky flags 0.
- **Assembler:**
  - Counter `beat` runs 0..RATIO-1 and advances only on `din_valid`. Idle cycles between beats are allowed.
  - Beats are packed LSB-first: beat k fills bits `[k*PIN_W +: PIN_W]`.
  - `mode` is latched on beat 0.
  - On the beat with `beat==RATIO-1`: `core_din`, `core_mode` and a `core_din_valid` pulse are registered, and `beat` returns to 0.
  - `core_din` holds its value between pulses.
- **Resync:** `din_valid & din_sof` forces the beat to be treated as beat 0.
  - If `beat != 0` at that point, the partial word is discarded and `err_resync` is set.
  - `din_sof` without `din_valid` is ignored.
- **RATIO=1:** every valid beat produces a word. `din_sof` never sets `err_resync`.
- **FIFO write:** on `core_dout_valid`, `{start, mode, data}` is written.
  - If full, the write is dropped, `err_overflow` is set, and contents are unchanged. This holds even when a read occurs in the same cycle.
- **FIFO read:** on `dout_valid & dout_ready`, the head is popped. `dout_ready` while empty has no effect.
- **Simultaneous read and write when not full and not empty:** count unchanged, both operations take effect.
- **Write while empty with `dout_ready` high:** the word is stored. No pop occurs that cycle.
- **Pointers:** `log2(FIFO_DEPTH)` bits, wrap naturally. Count width is `log2(FIFO_DEPTH)+1`.
- **`core_stall`:** registered from the next-state count. It is advisory; the core may still write, and any write beyond full counts as overflow.
- **`clr_err`:** clears both sticky flags. A same-cycle set event wins over the clear.

## Timing

- **Input latency:** last beat sampled at edge N → `core_din_valid`, `core_din` and `core_mode` are valid after edge N and pulse for exactly one cycle.
- **Input throughput:** maximum one word per RATIO cycles.
- **Output show-ahead:**
  - Write at edge N into an empty FIFO → `dout_valid`=1 and `dout*` = the entry after edge N.
  - Pop at edge M → the next head, or `dout_valid`=0, after edge M.
- **Output throughput:** sustained one sample per cycle when `dout_ready` is held high.
- **`core_stall`:** updates after the same edge as the count change.
- **Reset mid-operation:** asynchronous assertion clears all state immediately, discarding partial words and FIFO contents. Deassertion is synchronous to `clk` (external synchroniser).

## Test plan

1. **Assembly:** PIN_W=8, WORD_W=16. Beats 0x34 (mode=1) then 0x12, with 3 idle cycles between → single pulse `core_din`=0x1234, `core_mode`=1, one cycle after the second beat.
2. **Resync:** beat 0xAA, then `din_sof` beat 0x55, then 0x66 → `core_din`=0x6655, `err_resync`=1. After `clr_err` → `err_resync`=0.
3. **FIFO flow:** write 0x01..0x05 with `dout_ready`=0 → `dout`=0x01, `dout_valid`=1. Then `dout_ready`=1 for 5 cycles → pad sees 0x01..0x05 in order, then `dout_valid`=0.
4. **Full and stall:** FIFO_DEPTH=16, AFULL_MARGIN=4. 17 writes with no reads →
   - `core_stall` rises after the 12th write;
   - 17th write dropped, `err_overflow`=1;
   - reads return the first 16 values.
5. **Simultaneous read and write:** at count 1, concurrent write 0x7 and read → count stays 1, head becomes 0x7. Tags `start`=1, `mode`=0 propagate unchanged.
6. **Reset mid-operation:** assert `rstn`=0 mid-word with FIFO holding 3 entries → all outputs 0 immediately. After release, a fresh two-beat word assembles correctly.
